// File: rtl/aes_pkg.sv
// aes_pkg: shared FSM states, row offsets and byte layout for the ShiftRows engine.
package aes_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  function automatic bit nb_legal(int nb);
    return nb inside {4, 6, 8};
  endfunction
  // Rijndael row shifts: the wide 8-column state skips offset 2
  function automatic int row_offset(int nb, int r);
    return (nb == 8 && r > 1) ? r + 1 : r;
  endfunction
  function automatic int byte_idx(int r, int c);
    return 4 * c + r;
  endfunction
endpackage

// File: rtl/rowshift_row.sv
// rowshift_row: one state row cyclically shifted (forward or inverse) and optionally keyed.
module rowshift_row
  import aes_pkg::*;
#(
  parameter int NB      = 4,
  parameter bit ADD_KEY = 0
) (
  input  logic [1:0]         row,
  input  logic               dir,
  input  logic [32*NB-1:0]   state,
  input  logic [32*NB-1:0]   key,
  output logic [8*NB-1:0]    shifted
);
  for (genvar c = 0; c < NB; c++) begin : g_col
    logic [7:0] fwd [4];
    logic [7:0] inv [4];
    logic [7:0] kb  [4];
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign fwd[r] = state[8*byte_idx(r, (c + row_offset(NB, r)) % NB) +: 8];
      assign inv[r] = state[8*byte_idx(r, (c - row_offset(NB, r) + NB) % NB) +: 8];
      assign kb[r]  = key[8*byte_idx(r, c) +: 8];
    end
    assign shifted[8*c +: 8] = (dir ? inv[row] : fwd[row]) ^ (kb[row] & {8{ADD_KEY}});
  end
endmodule

// File: rtl/shiftrows_engine.sv
// shiftrows_engine: iterative ShiftRows/InvShiftRows with optional AddRoundKey, one row per cycle.
module shiftrows_engine
  import aes_pkg::*;
#(
  parameter int NB      = 4,
  parameter bit ADD_KEY = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               dir,
  input  logic [32*NB-1:0]   in,
  input  logic [32*NB-1:0]   key,
  output logic               finish,
  output logic               busy,
  output logic [32*NB-1:0]   shiftrowsstep
);
  localparam int W = 32 * NB;
  if (!nb_legal(NB)) begin : g_bad_nb
    $fatal(1, "shiftrows_engine: NB must be 4, 6 or 8");
  end
  state_t           state, nxt;
  logic [1:0]       rowcnt;
  logic             dir_q;
  logic [W-1:0]     in_q, key_q, work, merged;
  logic [8*NB-1:0]  row_bytes;
  rowshift_row #(.NB(NB), .ADD_KEY(ADD_KEY)) u_row (
    .row(rowcnt), .dir(dir_q), .state(in_q), .key(key_q), .shifted(row_bytes)
  );
  // working result with the current row spliced in; on the last row this is the full answer
  always_comb begin
    merged = work;
    for (int c = 0; c < NB; c++)
      for (int r = 0; r < 4; r++)
        merged[8*byte_idx(r, c) +: 8] = rowcnt == 2'(r) ? row_bytes[8*c +: 8] : work[8*byte_idx(r, c) +: 8];
  end
  always_comb begin
    nxt = state == IDLE ? (start ? BUSY : IDLE)
        : state == BUSY ? (!start ? IDLE : rowcnt == 2'd3 ? DONE : BUSY)
        : (start ? DONE : IDLE);
  end
  assign busy   = state == BUSY;
  assign finish = state == DONE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      rowcnt        <= 2'd0;
      dir_q         <= 1'b0;
      in_q          <= '0;
      key_q         <= '0;
      work          <= '0;
      shiftrowsstep <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        in_q   <= in;
        key_q  <= key;
        dir_q  <= dir;
        rowcnt <= 2'd0;
      end
      if (state == BUSY && start) begin
        work   <= merged;
        rowcnt <= rowcnt + 2'd1;
        if (rowcnt == 2'd3) shiftrowsstep <= merged;
      end
    end
  end
endmodule

// File: tb/tb_shiftrows_engine.sv
// tb_shiftrows_engine: random and directed checks of four engine configurations against a byte-array model.
module tb_shiftrows_engine;
  logic clk = 0, rst = 0, start = 0, dir = 0;
  logic [255:0] in_v = '0, key_v = '0;
  logic [127:0] o4, o4k;
  logic [191:0] o6k;
  logic [255:0] o8;
  logic f4, f4k, f6k, f8, b4, b4k, b6k, b8;
  logic [3:0] fin, bsy;
  int ntot = 0, npass = 0;
  assign fin = {f4, f4k, f6k, f8};
  assign bsy = {b4, b4k, b6k, b8};
  always #5 clk = ~clk;

  shiftrows_engine #(.NB(4), .ADD_KEY(0)) u4 (.clk(clk), .rst(rst), .start(start), .dir(dir),
    .in(in_v[127:0]), .key(key_v[127:0]), .finish(f4), .busy(b4), .shiftrowsstep(o4));
  shiftrows_engine #(.NB(4), .ADD_KEY(1)) u4k (.clk(clk), .rst(rst), .start(start), .dir(dir),
    .in(in_v[127:0]), .key(key_v[127:0]), .finish(f4k), .busy(b4k), .shiftrowsstep(o4k));
  shiftrows_engine #(.NB(6), .ADD_KEY(1)) u6k (.clk(clk), .rst(rst), .start(start), .dir(dir),
    .in(in_v[191:0]), .key(key_v[191:0]), .finish(f6k), .busy(b6k), .shiftrowsstep(o6k));
  shiftrows_engine #(.NB(8), .ADD_KEY(0)) u8 (.clk(clk), .rst(rst), .start(start), .dir(dir),
    .in(in_v), .key(key_v), .finish(f8), .busy(b8), .shiftrowsstep(o8));

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // reference: state viewed as a 4 x nb byte matrix, each row rotated by its Rijndael offset
  function automatic logic [255:0] ref_sr(int nb, bit ak, bit d, logic [255:0] a, logic [255:0] k);
    logic [7:0] m [4][8];
    logic [255:0] o = '0;
    int s, src;
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++) m[r][c] = a[8*(4*c+r) +: 8];
    for (int r = 0; r < 4; r++) begin
      s = (nb == 8 && r >= 2) ? r + 1 : r;
      for (int c = 0; c < nb; c++) begin
        src = d ? (c - s + nb) % nb : (c + s) % nb;
        o[8*(4*c+r) +: 8] = m[r][src] ^ (ak ? k[8*(4*c+r) +: 8] : 8'h00);
      end
    end
    return o;
  endfunction

  task automatic run(input bit d, input logic [255:0] a, input logic [255:0] k);
    @(negedge clk);
    dir = d; in_v = a; key_v = k; start = 1;
    @(posedge clk); #1;
    in_v = rnd256(); key_v = rnd256(); dir = ~d;
    chk("busy_after_capture", {fin, bsy}, {4'h0, 4'hf});
    repeat (3) begin
      @(posedge clk); #1;
      chk("busy_rows", {fin, bsy}, {4'h0, 4'hf});
    end
    @(posedge clk); #1;
    chk("done_flags", {fin, bsy}, {4'hf, 4'h0});
    chk("o4", o4, ref_sr(4, 0, d, a, k));
    chk("o4k", o4k, ref_sr(4, 1, d, a, k));
    chk("o6k", o6k, ref_sr(6, 1, d, a, k));
    chk("o8", o8, ref_sr(8, 0, d, a, k));
    @(negedge clk);
    start = 0;
    @(posedge clk); #1;
    chk("idle_flags", {fin, bsy}, 8'h00);
  endtask

  initial begin
    logic [255:0] p8, p4, p4k, p6k, pat;
    repeat (2) @(negedge clk);
    chk("reset_flags", {fin, bsy}, 8'h00);
    chk("reset_o8", o8, '0);
    chk("reset_o4k", o4k, '0);
    rst = 1;
    run(0, 256'h2a179373117e3de9969f402ee2bec16b, rnd256());
    chk("vec_fwd", o4, 128'h119fc17396be93e9e2173d2e2a7e406b);
    run(1, 256'hacac2d459c8aaf9e578eb71e516f03ae, rnd256());
    chk("vec_inv", o4, 128'h518eaf45ac6fb79e9cac031e578a2dae);
    run(0, {128'h0, o4}, rnd256());
    chk("vec_roundtrip", o4, 128'hacac2d459c8aaf9e578eb71e516f03ae);
    run(0, '0, 256'h3c4fcf098815f7aba6d2ae2816157e2b);
    chk("addkey_zero_in", o4k, 128'h3c4fcf098815f7aba6d2ae2816157e2b);
    for (int b = 0; b < 32; b++) pat[8*b +: 8] = 8'(b);
    run(0, pat, rnd256());
    chk("nb8_low_word", o8[31:0], 32'h130e0500);
    run(1, o8, rnd256());
    chk("nb8_roundtrip", o8, pat);
    for (int i = 0; i < 20; i++) run(1'($urandom), rnd256(), rnd256());
    // abort: start dropped in the second BUSY cycle
    p4 = o4; p4k = o4k; p6k = o6k; p8 = o8;
    @(negedge clk);
    start = 1; in_v = rnd256(); key_v = rnd256(); dir = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    start = 0;
    @(posedge clk); #1;
    chk("abort_flags", {fin, bsy}, 8'h00);
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_no_finish", fin, 4'h0);
    end
    chk("abort_o4", o4, p4[127:0]);
    chk("abort_o4k", o4k, p4k[127:0]);
    chk("abort_o6k", o6k, p6k[191:0]);
    chk("abort_o8", o8, p8);
    // asynchronous reset while holding DONE
    @(negedge clk);
    start = 1; in_v = rnd256(); key_v = rnd256(); dir = 1;
    repeat (5) @(posedge clk);
    #1 chk("hold_done", fin, 4'hf);
    @(negedge clk);
    #2 rst = 0;
    #1;
    chk("async_rst_flags", {fin, bsy}, 8'h00);
    chk("async_rst_o8", o8, '0);
    chk("async_rst_o4", o4, '0);
    start = 0;
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 4; i++) run(1'(i), rnd256(), rnd256());
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
